// File: rtl/pacman_pkg.sv
// Shared constants, enums and map-layout helpers for the Pac-Man tile responder.
package pacman_pkg;

    localparam int unsigned MAP_W     = 48;
    localparam int unsigned MAP_H     = 27;
    localparam int unsigned TILE_PX   = 40;
    localparam int unsigned PAC_SIZE  = 40;
    localparam int unsigned STEP      = 4;
    localparam int unsigned SCR_W     = 1920;
    localparam int unsigned SCR_H     = 1080;
    localparam int unsigned N_TILES   = MAP_W * MAP_H;
    localparam int unsigned SPAWN_COL = 24;
    localparam int unsigned SPAWN_ROW = 13;

    localparam logic [3:0] TILE_BG   = 4'd0;
    localparam logic [3:0] TILE_WALL = 4'd1;
    localparam logic [3:0] TILE_COIN = 4'd2;

    typedef enum logic [2:0] {HdNone, HdUp, HdLeft, HdRight, HdDown} heading_t;
    typedef enum logic [2:0] {StClear, StIdle, StDiv, StProbe, StEat} state_t;

    // Border ring plus short horizontal bars every sixth row.
    function automatic logic is_wall(input logic [5:0] row, input logic [5:0] col);
        logic [2:0] c8;
        c8 = col[2:0];
        return (row == 6'd0) || (row == 6'(MAP_H - 1)) ||
               (col == 6'd0) || (col == 6'(MAP_W - 1)) ||
               (((row % 6'd6) == 6'd3) && (c8 >= 3'd2) && (c8 <= 3'd5));
    endfunction

    function automatic logic [10:0] addr_of(input logic [5:0] row, input logic [5:0] col);
        return 11'(row) * 11'(MAP_W) + 11'(col);
    endfunction

    function automatic logic [3:0] code_of(input logic wall, input logic coin);
        if (wall) return TILE_WALL;
        if (coin) return TILE_COIN;
        return TILE_BG;
    endfunction

endpackage

// File: rtl/tile_div40.sv
// Iterative divide-by-TILE_PX using repeated subtraction; done holds until the next start.
module tile_div40
    import pacman_pkg::*;
(
    input  logic        clk_pix,
    input  logic        rstn,
    input  logic        i_start,
    input  logic [11:0] i_dividend,
    output logic        o_done,
    output logic [5:0]  o_quot
);

    logic [11:0] r_rem;
    logic [5:0]  r_quot;
    logic        r_run;
    logic        r_done;

    always_ff @(posedge clk_pix) begin
        if (!rstn) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_dividend;
            r_quot <= '0;
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            if (r_rem >= 12'(TILE_PX)) begin
                r_rem  <= r_rem - 12'(TILE_PX);
                r_quot <= r_quot + 6'd1;
            end else begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_quot;

endmodule

// File: rtl/pacman_tile_resp.sv
// Tile-map responder: per-frame look-ahead probe lookup, coin eating/scoring and a
// registered tile read port for the renderer.
module pacman_tile_resp
    import pacman_pkg::*;
#(
    parameter int unsigned SCORE_W = 16
) (
    input  logic               clk_pix,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic [4:0]         btn_pulse,
    input  logic [11:0]        pac_x,
    input  logic [11:0]        pac_y,
    output logic [10:0]        tile_addr,
    output logic [3:0]         tile_code,
    output logic               coin_eaten,
    output logic [SCORE_W-1:0] score,
    output logic [10:0]        coins_left,
    output logic               busy,
    input  logic [10:0]        rd_addr,
    output logic [3:0]         rd_code
);

    localparam logic [11:0] HALF  = 12'(PAC_SIZE / 2);
    localparam logic [11:0] LOOK  = 12'(PAC_SIZE + STEP - 1);
    localparam logic [11:0] STP   = 12'(STEP);
    localparam logic [11:0] X_MAX = 12'(SCR_W - 1);
    localparam logic [11:0] Y_MAX = 12'(SCR_H - 1);

    state_t             r_state, w_state_nxt;
    logic [N_TILES-1:0] r_coin;
    logic [10:0]        r_clr_addr;
    logic [5:0]         r_clr_row, r_clr_col;
    logic               r_tick;
    logic [11:0]        r_x, r_y;
    heading_t           r_hd, w_hd;
    logic               r_phase, r_div_start;
    logic [5:0]         r_p_row, r_p_col, r_c_row, r_c_col;
    logic [10:0]        r_tile_addr;
    logic [3:0]         r_tile_code;
    logic               r_coin_eaten;
    logic [SCORE_W-1:0] r_score;
    logic [10:0]        r_coins_left;
    logic [3:0]         r_rd_code;

    logic [11:0] w_px, w_py, w_cx, w_cy;
    logic        w_dx_done, w_dy_done, w_div_done;
    logic [5:0]  w_qx, w_qy;
    logic        w_clr_coin;
    logic [10:0] w_p_addr, w_c_addr;
    logic [3:0]  w_p_code;
    logic        w_c_coin;
    logic [5:0]  w_rd_row, w_rd_col;
    logic [3:0]  w_rd_code;
    logic        w_unused_mid;

    assign w_unused_mid = btn_pulse[2];

    always_comb begin
        if (btn_pulse[0])      w_hd = HdUp;
        else if (btn_pulse[1]) w_hd = HdLeft;
        else if (btn_pulse[3]) w_hd = HdRight;
        else if (btn_pulse[4]) w_hd = HdDown;
        else                   w_hd = HdNone;
    end

    always_comb begin
        w_cx = r_x + HALF;
        w_cy = r_y + HALF;
        w_px = w_cx;
        w_py = w_cy;
        unique case (r_hd)
            HdUp:    w_py = (r_y < STP) ? 12'd0 : r_y - STP;
            HdDown:  w_py = (r_y + LOOK > Y_MAX) ? Y_MAX : r_y + LOOK;
            HdLeft:  w_px = (r_x < STP) ? 12'd0 : r_x - STP;
            HdRight: w_px = (r_x + LOOK > X_MAX) ? X_MAX : r_x + LOOK;
            default: ;
        endcase
    end

    tile_div40 u_div_x (
        .clk_pix    (clk_pix),
        .rstn       (rstn),
        .i_start    (r_div_start),
        .i_dividend (r_phase ? w_cx : w_px),
        .o_done     (w_dx_done),
        .o_quot     (w_qx)
    );

    tile_div40 u_div_y (
        .clk_pix    (clk_pix),
        .rstn       (rstn),
        .i_start    (r_div_start),
        .i_dividend (r_phase ? w_cy : w_py),
        .o_done     (w_dy_done),
        .o_quot     (w_qy)
    );

    // The dividers' done flags are stale during the start cycle.
    assign w_div_done = w_dx_done && w_dy_done && !r_div_start;

    assign w_clr_coin = !is_wall(r_clr_row, r_clr_col) &&
                        !((r_clr_row == 6'(SPAWN_ROW)) && (r_clr_col == 6'(SPAWN_COL)));

    assign w_p_addr = addr_of(r_p_row, r_p_col);
    assign w_p_code = code_of(is_wall(r_p_row, r_p_col), r_coin[w_p_addr]);
    assign w_c_addr = addr_of(r_c_row, r_c_col);
    assign w_c_coin = !is_wall(r_c_row, r_c_col) && r_coin[w_c_addr];

    assign w_rd_row  = 6'(rd_addr / 11'(MAP_W));
    assign w_rd_col  = 6'(rd_addr - 11'(w_rd_row) * 11'(MAP_W));
    assign w_rd_code = ((rd_addr >= 11'(N_TILES)) || (r_state == StClear)) ? TILE_BG :
                       code_of(is_wall(w_rd_row, w_rd_col), r_coin[rd_addr]);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StClear: if (r_clr_addr == 11'(N_TILES - 1)) w_state_nxt = StIdle;
            StIdle:  if (r_tick) w_state_nxt = StDiv;
            StDiv:   if (w_div_done && r_phase) w_state_nxt = StProbe;
            StProbe: w_state_nxt = StEat;
            StEat:   w_state_nxt = StIdle;
            default: w_state_nxt = StClear;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (!rstn) begin
            r_state      <= StClear;
            r_clr_addr   <= '0;
            r_clr_row    <= '0;
            r_clr_col    <= '0;
            r_tick       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_hd         <= HdNone;
            r_phase      <= 1'b0;
            r_div_start  <= 1'b0;
            r_p_row      <= '0;
            r_p_col      <= '0;
            r_c_row      <= '0;
            r_c_col      <= '0;
            r_tile_addr  <= '0;
            r_tile_code  <= TILE_BG;
            r_coin_eaten <= 1'b0;
            r_score      <= '0;
            r_coins_left <= '0;
            r_rd_code    <= TILE_BG;
        end else begin
            r_state      <= w_state_nxt;
            r_coin_eaten <= 1'b0;
            r_div_start  <= 1'b0;
            r_rd_code    <= w_rd_code;
            unique case (r_state)
                StClear: begin
                    if (w_clr_coin) r_coins_left <= r_coins_left + 11'd1;
                    r_clr_addr <= r_clr_addr + 11'd1;
                    if (r_clr_col == 6'(MAP_W - 1)) begin
                        r_clr_col <= '0;
                        r_clr_row <= r_clr_row + 6'd1;
                    end else begin
                        r_clr_col <= r_clr_col + 6'd1;
                    end
                end
                StIdle: begin
                    // Latch one cycle after the tick so the controller's new position is seen.
                    r_tick <= frame_tick;
                    if (r_tick) begin
                        r_tick      <= 1'b0;
                        r_x         <= pac_x;
                        r_y         <= pac_y;
                        r_hd        <= w_hd;
                        r_phase     <= 1'b0;
                        r_div_start <= 1'b1;
                    end
                end
                StDiv: begin
                    if (w_div_done) begin
                        if (!r_phase) begin
                            r_p_row     <= w_qy;
                            r_p_col     <= w_qx;
                            r_phase     <= 1'b1;
                            r_div_start <= 1'b1;
                        end else begin
                            r_c_row <= w_qy;
                            r_c_col <= w_qx;
                        end
                    end
                end
                StProbe: begin
                    r_tile_addr <= w_p_addr;
                    r_tile_code <= w_p_code;
                end
                StEat: begin
                    if (w_c_coin) begin
                        r_coin_eaten <= 1'b1;
                        if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + SCORE_W'(1);
                        if (r_coins_left != 11'd0) r_coins_left <= r_coins_left - 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Coin bits are fully rewritten by the sweep, so they carry no reset.
    always_ff @(posedge clk_pix) begin
        if (r_state == StClear) begin
            r_coin[r_clr_addr] <= w_clr_coin;
        end else if ((r_state == StEat) && w_c_coin) begin
            r_coin[w_c_addr] <= 1'b0;
        end
    end

    assign tile_addr  = r_tile_addr;
    assign tile_code  = r_tile_code;
    assign coin_eaten = r_coin_eaten;
    assign score      = r_score;
    assign coins_left = r_coins_left;
    assign busy       = (r_state != StIdle);
    assign rd_code    = r_rd_code;

endmodule

// File: tb/tb_pacman_tile_resp.sv
// Randomized self-checking bench for pacman_tile_resp against an arithmetic map/coin model.
module tb_pacman_tile_resp;

    logic        clk_pix = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_tick = 1'b0;
    logic [4:0]  btn_pulse = '0;
    logic [11:0] pac_x = '0, pac_y = '0;
    logic [10:0] rd_addr = '0;
    logic [10:0] tile_addr;
    logic [3:0]  tile_code;
    logic        coin_eaten;
    logic [15:0] score;
    logic [10:0] coins_left;
    logic        busy;
    logic [3:0]  rd_code;

    int n_checks = 0;
    int n_fails  = 0;
    int n_pulse  = 0;
    bit model_coin [1296];
    int m_score, m_left;

    pacman_tile_resp #(.SCORE_W(16)) dut (
        .clk_pix    (clk_pix),
        .rstn       (rstn),
        .frame_tick (frame_tick),
        .btn_pulse  (btn_pulse),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .tile_addr  (tile_addr),
        .tile_code  (tile_code),
        .coin_eaten (coin_eaten),
        .score      (score),
        .coins_left (coins_left),
        .busy       (busy),
        .rd_addr    (rd_addr),
        .rd_code    (rd_code)
    );

    always #5 clk_pix = ~clk_pix;

    always @(negedge clk_pix) if (coin_eaten === 1'b1) n_pulse++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_wall(input int r, input int c);
        return r == 0 || r == 26 || c == 0 || c == 47 ||
               (r % 6 == 3 && c % 8 >= 2 && c % 8 <= 5);
    endfunction

    function automatic int m_code(input int a);
        if (a >= 1296) return 0;
        if (m_wall(a / 48, a % 48)) return 1;
        return model_coin[a] ? 2 : 0;
    endfunction

    task automatic model_reset();
        m_score = 0;
        m_left  = 0;
        for (int a = 0; a < 1296; a++) begin
            model_coin[a] = !m_wall(a / 48, a % 48) && (a != 13 * 48 + 24);
            if (model_coin[a]) m_left++;
        end
    endtask

    task automatic wait_clear();
        int cyc = 0;
        do begin
            @(posedge clk_pix);
            cyc++;
            #1;
            if (cyc == 100) begin
                frame_tick = 1'b1;
                rd_addr = 11'd0;
            end else begin
                frame_tick = 1'b0;
            end
            if (cyc == 102) check_eq("rd_during_clear", rd_code, 0);
        end while (busy && cyc < 3000);
        check_eq("clear_cycles", cyc, 1296);
    endtask

    task automatic query(input int x, input int y, input logic [4:0] btn);
        int px, py, cx, cy, pa, ca, exp_code, lat, p0;
        bit eat;
        cx = x + 20;
        cy = y + 20;
        px = cx;
        py = cy;
        if (btn[0])      py = (y < 4) ? 0 : y - 4;
        else if (btn[1]) px = (x < 4) ? 0 : x - 4;
        else if (btn[3]) px = (x + 43 > 1919) ? 1919 : x + 43;
        else if (btn[4]) py = (y + 43 > 1079) ? 1079 : y + 43;
        pa = (py / 40) * 48 + px / 40;
        ca = (cy / 40) * 48 + cx / 40;
        exp_code = m_code(pa);
        eat = (m_code(ca) == 2);
        p0 = n_pulse;
        @(negedge clk_pix);
        frame_tick = 1'b1;
        pac_x = 12'($urandom);
        pac_y = 12'($urandom);
        btn_pulse = 5'($urandom);
        rd_addr = 11'(ca);
        @(negedge clk_pix);
        frame_tick = 1'b0;
        pac_x = 12'(x);
        pac_y = 12'(y);
        btn_pulse = btn;
        lat = 0;
        do begin
            @(negedge clk_pix);
            lat++;
            frame_tick = (lat == 5);
        end while (busy && lat < 300);
        frame_tick = 1'b0;
        check_eq("query_done", busy, 0);
        check_eq("latency_le_110", lat <= 110, 1);
        check_eq("rd_eat_cycle_preclear", rd_code, m_code(ca));
        if (eat) begin
            model_coin[ca] = 1'b0;
            m_score++;
            m_left--;
        end
        repeat (2) @(negedge clk_pix);
        check_eq("tile_addr", tile_addr, pa);
        check_eq("tile_code", tile_code, exp_code);
        check_eq("score", score, m_score);
        check_eq("coins_left", coins_left, m_left);
        check_eq("coin_pulses", n_pulse - p0, eat);
        check_eq("idle_after_query", busy, 0);
        check_eq("rd_after_eat", rd_code, m_code(ca));
    endtask

    task automatic rd_check(input int a);
        @(negedge clk_pix);
        rd_addr = 11'(a);
        @(negedge clk_pix);
        check_eq("rd_code", rd_code, m_code(a));
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_tile_addr"}, tile_addr, 0);
        check_eq({tag, "_tile_code"}, tile_code, 0);
        check_eq({tag, "_coin_eaten"}, coin_eaten, 0);
        check_eq({tag, "_score"}, score, 0);
        check_eq({tag, "_coins_left"}, coins_left, 0);
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_rd_code"}, rd_code, 0);
    endtask

    task automatic after_clear_checks();
        check_eq("init_coins_left", coins_left, 1053);
        check_eq("init_score", score, 0);
        check_eq("init_tile_code", tile_code, 0);
        check_eq("init_no_pulse", n_pulse, 0);
        repeat (3) @(negedge clk_pix);
        check_eq("tick_in_clear_ignored", busy, 0);
    endtask

    initial begin
        model_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk_pix);
        reset_checks("reset");
        rstn = 1'b1;
        wait_clear();
        after_clear_checks();

        query(940, 520, 5'b00001);
        query(40, 40, 5'b00010);
        query(140, 60, 5'b00000);
        query(140, 60, 5'b00000);
        rd_check(100);
        rd_check(0);
        rd_check(1300);
        query(0, 0, 5'b00001);
        query(0, 0, 5'b00010);
        query(1880, 1040, 5'b10000);
        query(1880, 1040, 5'b01000);
        query(1880, 1040, 5'b00100);
        query(600, 300, 5'b11010);

        for (int i = 0; i < 40; i++) begin
            query(int'($urandom_range(1880)), int'($urandom_range(1040)), 5'($urandom));
        end
        for (int i = 0; i < 20; i++) rd_check(int'($urandom_range(2047)));

        // Reset in the middle of a query.
        @(negedge clk_pix);
        frame_tick = 1'b1;
        @(negedge clk_pix);
        frame_tick = 1'b0;
        pac_x = 12'd1880;
        pac_y = 12'd1040;
        btn_pulse = 5'b01000;
        repeat (6) @(negedge clk_pix);
        check_eq("mid_div_busy", busy, 1);
        rstn = 1'b0;
        @(negedge clk_pix);
        reset_checks("midreset");
        rstn = 1'b1;
        model_reset();
        n_pulse = 0;
        wait_clear();
        after_clear_checks();
        query(140, 60, 5'b00000);
        rd_check(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
